// File: rtl/move_check_dispatch.sv
// Initiator for the per-piece move checkers: validates source/target ownership,
// starts the checker for the source piece and returns its verdict or a timeout.
module move_check_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    // Handshake: a request transfers on a clock edge where req_valid && req_ready.
    // The response is a one-cycle resp_valid strobe with no backpressure.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            old_x,
    input  logic [2:0]            old_y,
    input  logic [2:0]            new_x,
    input  logic [2:0]            new_y,
    input  logic                  side,
    input  logic [7:0][7:0][3:0]  board_in,
    output logic                  chk_start,
    output logic [2:0]            chk_sel,
    output logic [2:0]            h_delta,
    output logic [2:0]            v_delta,
    output logic [3:0]            piece_type,
    input  logic                  chk_move_valid,
    input  logic                  chk_done,
    output logic                  resp_valid,
    output logic                  resp_legal,
    output logic [1:0]            resp_code,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DISPATCH = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [1:0] CODE_OK       = 2'd0;
    localparam logic [1:0] CODE_GEOMETRY = 2'd1;
    localparam logic [1:0] CODE_SQUARE   = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;
    localparam logic [7:0] LAST_WAIT     = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [2:0] ox_q, oy_q, nx_q, ny_q;
    logic       side_q;
    logic [7:0] wait_cnt;
    logic [3:0] src, dst;
    logic       pre_fail;
    logic [1:0] pre_code;

    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign req_ready = (state == IDLE);
    assign dbg_state = state;
    assign src       = board_in[oy_q][ox_q];
    assign dst       = board_in[ny_q][nx_q];

    // Ownership of the source outranks a null move, which outranks self-capture.
    always_comb begin
        pre_fail = 1'b1;
        pre_code = CODE_SQUARE;
        if (src[2:0] == 3'd0 || src[2:0] == 3'd7 || src[3] != side_q) begin
            pre_code = CODE_SQUARE;
        end else if (ox_q == nx_q && oy_q == ny_q) begin
            pre_code = CODE_GEOMETRY;
        end else if (dst != 4'd0 && dst[3] == side_q) begin
            pre_code = CODE_SQUARE;
        end else begin
            pre_fail = 1'b0;
            pre_code = CODE_OK;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            ox_q       <= 3'd0;
            oy_q       <= 3'd0;
            nx_q       <= 3'd0;
            ny_q       <= 3'd0;
            side_q     <= 1'b0;
            wait_cnt   <= 8'd0;
            chk_start  <= 1'b0;
            chk_sel    <= 3'd0;
            h_delta    <= 3'd0;
            v_delta    <= 3'd0;
            piece_type <= 4'd0;
            resp_valid <= 1'b0;
            resp_legal <= 1'b0;
            resp_code  <= 2'd0;
        end else begin
            chk_start  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ox_q   <= old_x;
                        oy_q   <= old_y;
                        nx_q   <= new_x;
                        ny_q   <= new_y;
                        side_q <= side;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    piece_type <= src;
                    chk_sel    <= src[2:0];
                    h_delta    <= abs_diff(ox_q, nx_q);
                    v_delta    <= abs_diff(oy_q, ny_q);
                    if (pre_fail) begin
                        resp_legal <= 1'b0;
                        resp_code  <= pre_code;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        chk_start <= 1'b1;
                        state     <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A done arriving on the last allowed cycle still wins over the timeout.
                    if (chk_done) begin
                        resp_legal <= chk_move_valid;
                        resp_code  <= chk_move_valid ? CODE_OK : CODE_GEOMETRY;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        resp_legal <= 1'b0;
                        resp_code  <= CODE_TIMEOUT;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_check_dispatch.sv
// Bench for move_check_dispatch: directed cases plus random boards checked
// against a rule-level model of verdict, reason code and response cycle.
module tb_move_check_dispatch;

    localparam int T = 8;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           old_x, old_y, new_x, new_y;
    logic                 side;
    logic [7:0][7:0][3:0] board_in;
    logic                 chk_start;
    logic [2:0]           chk_sel, h_delta, v_delta;
    logic [3:0]           piece_type;
    logic                 chk_move_valid, chk_done;
    logic                 resp_valid, resp_legal;
    logic [1:0]           resp_code;
    logic [2:0]           dbg_state;

    logic [3:0] bd [8][8];
    int n_checks = 0;
    int n_errors = 0;

    move_check_dispatch #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .side(side), .board_in(board_in),
        .chk_start(chk_start), .chk_sel(chk_sel),
        .h_delta(h_delta), .v_delta(v_delta), .piece_type(piece_type),
        .chk_move_valid(chk_move_valid), .chk_done(chk_done),
        .resp_valid(resp_valid), .resp_legal(resp_legal), .resp_code(resp_code),
        .dbg_state(dbg_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                bd[y][x] = 4'd0;
    endtask

    task automatic apply_board();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                board_in[y][x] = bd[y][x];
    endtask

    // done_at: WAIT-relative cycle of chk_done (0 = first WAIT cycle),
    // -1 never, -2 a stray pulse during the start cycle only.
    task automatic run_req(input int ox, input int oy, input int nx, input int ny,
                           input logic sd, input int done_at, input logic vld,
                           input bit hold, input bit b2b, input bit scramble);
        logic [3:0] src, dst;
        int exp_code, exp_legal, exp_cyc, exp_h, exp_v;
        bit pass, seen;
        int waits, n_start, start_cyc, resp_cyc;
        int got_code, got_legal, got_sel, got_h, got_v, got_pt;

        src = bd[oy][ox];
        dst = bd[ny][nx];
        pass = 1'b0;
        if (src[2:0] == 0 || src[2:0] == 7 || src[3] != sd) exp_code = 2;
        else if (ox == nx && oy == ny) exp_code = 1;
        else if (dst != 0 && dst[3] == sd) exp_code = 2;
        else pass = 1'b1;
        exp_legal = 0;
        if (!pass) exp_cyc = 2;
        else if (done_at >= 0 && done_at < T) begin
            exp_cyc = 4 + done_at;
            exp_code = vld ? 0 : 1;
            exp_legal = vld ? 1 : 0;
        end else begin
            exp_cyc = 3 + T;
            exp_code = 3;
        end
        exp_h = (ox > nx) ? ox - nx : nx - ox;
        exp_v = (oy > ny) ? oy - ny : ny - oy;

        @(negedge CLOCK_50);
        old_x = 3'(ox); old_y = 3'(oy); new_x = 3'(nx); new_y = 3'(ny);
        side = sd;
        apply_board();
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge CLOCK_50);
            waits++;
        end
        if (b2b) check_eq("b2b_accept_wait", waits, 0);
        @(posedge CLOCK_50);
        #1;
        if (!hold) req_valid = 1'b0;

        seen = 1'b0; n_start = 0; start_cyc = -1; resp_cyc = -1;
        got_code = 0; got_legal = 0; got_sel = 0; got_h = 0; got_v = 0; got_pt = 0;
        for (int cyc = 1; cyc <= 3 + T + 3; cyc++) begin
            chk_done = (cyc == 3 + done_at && done_at >= 0) || (done_at == -2 && cyc == 2);
            chk_move_valid = chk_done ? vld : 1'($urandom_range(0, 1));
            if (scramble && cyc == 2)
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++)
                        board_in[y][x] = 4'($urandom_range(0, 15));
            @(negedge CLOCK_50);
            if (chk_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (resp_valid) begin
                seen = 1'b1; resp_cyc = cyc;
                got_code = resp_code; got_legal = resp_legal;
                got_sel = chk_sel; got_h = h_delta; got_v = v_delta; got_pt = piece_type;
                break;
            end
            @(posedge CLOCK_50);
            #1;
        end
        chk_done = 1'b0;

        check_eq("resp_seen", seen, 1);
        if (seen) begin
            check_eq("resp_cycle", resp_cyc, exp_cyc);
            check_eq("resp_code", got_code, exp_code);
            check_eq("resp_legal", got_legal, exp_legal);
            check_eq("start_count", n_start, pass ? 1 : 0);
            if (pass) check_eq("start_cycle", start_cyc, 2);
            check_eq("chk_sel", got_sel, int'(src[2:0]));
            check_eq("piece_type", got_pt, int'(src));
            check_eq("h_delta", got_h, exp_h);
            check_eq("v_delta", got_v, exp_v);
        end
    endtask

    initial begin
        bit bad_resp, bad_start;
        reset = 1'b1; req_valid = 1'b0;
        old_x = 0; old_y = 0; new_x = 0; new_y = 0; side = 0;
        chk_done = 0; chk_move_valid = 0;
        clear_board();
        apply_board();
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_eq("rst_chk_start", chk_start, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_sel_pt", {chk_sel, piece_type}, 0);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        check_eq("ready_after_reset", req_ready, 1);

        // Directed cases
        bd[0][1] = 4'h2; bd[0][2] = 4'h3; bd[0][3] = 4'h5; bd[4][3] = 4'h4;
        bd[4][4] = 4'hA; bd[6][6] = 4'h7; bd[7][7] = 4'hC;
        run_req(1, 0, 2, 2, 0, 0, 1, 0, 0, 1);        // knight legal, fastest path
        run_req(2, 0, 2, 3, 0, 1, 0, 0, 0, 0);        // bishop, checker rejects
        run_req(5, 5, 5, 6, 0, 0, 1, 0, 0, 0);        // empty source
        run_req(4, 4, 4, 5, 0, 0, 1, 0, 0, 0);        // opponent's piece
        run_req(3, 0, 3, 4, 0, 0, 1, 0, 0, 0);        // captures own rook
        run_req(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);        // null move
        run_req(6, 6, 6, 5, 0, 0, 1, 0, 0, 0);        // invalid piece code 7
        run_req(4, 4, 3, 4, 1, 2, 1, 0, 0, 0);        // black takes white rook
        run_req(1, 0, 2, 2, 0, -1, 1, 0, 0, 0);       // timeout
        run_req(1, 0, 2, 2, 0, T - 1, 1, 0, 0, 0);    // done on last WAIT cycle
        run_req(1, 0, 2, 2, 0, T - 1, 0, 0, 0, 0);
        run_req(1, 0, 2, 2, 0, -2, 1, 0, 0, 0);       // stray done before WAIT

        // Back-to-back with req_valid held, board scrambled after the first fetch
        run_req(1, 0, 2, 2, 0, 1, 1, 1, 0, 1);
        run_req(2, 0, 2, 3, 0, 0, 1, 1, 1, 1);
        run_req(5, 5, 5, 6, 0, 0, 1, 1, 1, 1);
        run_req(3, 0, 3, 4, 0, 0, 1, 0, 1, 0);

        // Reset in the middle of WAIT, then a late done
        @(negedge CLOCK_50);
        old_x = 1; old_y = 0; new_x = 2; new_y = 2; side = 0;
        apply_board();
        req_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #1 reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_eq("midrst_outputs", {chk_start, resp_valid, resp_legal, resp_code}, 0);
        check_eq("midrst_regs", {chk_sel, piece_type, h_delta, v_delta}, 0);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        chk_done = 1'b1; chk_move_valid = 1'b1;
        @(negedge CLOCK_50);
        check_eq("midrst_ready", req_ready, 1);
        @(posedge CLOCK_50);
        #1 chk_done = 1'b0;
        bad_resp = 0; bad_start = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLOCK_50);
            if (resp_valid) bad_resp = 1;
            if (chk_start) bad_start = 1;
        end
        check_eq("midrst_no_resp", bad_resp, 0);
        check_eq("midrst_no_start", bad_start, 0);

        // Random boards
        for (int n = 0; n < 40; n++) begin
            int ox, oy, nx, ny, da;
            logic sd;
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    bd[y][x] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
            nx = $urandom_range(0, 7); ny = $urandom_range(0, 7);
            sd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                bd[oy][ox] = {sd, 3'($urandom_range(1, 6))};
                if ($urandom_range(0, 1) == 0) bd[ny][nx] = 4'd0;
            end
            da = $urandom_range(0, 4);
            if (da == 4) da = $urandom_range(0, 1) ? -1 : $urandom_range(T - 2, T + 1);
            run_req(ox, oy, nx, ny, sd, da, 1'($urandom_range(0, 1)), 0, 0,
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
